// File: rtl/scan_digit_driver_pkg.sv
// Shared helpers for the multiplexed digit scanner:
// width derivation, one-hot decode and output polarity.
package scan_digit_driver_pkg;

  localparam int MAX_DIGITS = 32;

  // clog2 width, never below one bit
  function automatic int unsigned width_of(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] onehot(int unsigned i);
    return {{(MAX_DIGITS-1){1'b0}}, 1'b1} << i;
  endfunction

  // Map an active-high mask onto the pin polarity
  function automatic logic [MAX_DIGITS-1:0] drive(
    logic [MAX_DIGITS-1:0] m,
    bit                    active_low
  );
    return active_low ? ~m : m;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot counter for the digit scanner.
// Ports: clk, rst, en, hold in; slot_last, nxt_blank, nxt_last out.
module scan_prescaler
  import scan_digit_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  localparam int CNT_W       = width_of(SCAN_DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output logic slot_last,
  output logic nxt_blank,
  output logic nxt_last
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign slot_last = (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (!en)
      cnt_nxt = '0;
    else if (!hold)
      cnt_nxt = slot_last ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  // Phase of the upcoming cycle, so the top can register it
  assign nxt_last = (cnt_nxt == LAST);

  if (BLANK_CYCLES > 0) begin : g_blank
    assign nxt_blank = (cnt_nxt < CNT_W'(BLANK_CYCLES));
  end else begin : g_noblank
    assign nxt_blank = 1'b0;
  end

endmodule

// File: rtl/scan_digit_driver.sv
// Multiplexed-display digit scanner with blanking and masking.
// Ports: clk, rst, en, hold, digit_en in; digit_sel, digit_idx, tick, frame_done out.
module scan_digit_driver
  import scan_digit_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1,
  localparam int IDX_W       = width_of(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  hold,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  tick,
  output logic                  frame_done
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] OFF =
    NUM_DIGITS'(drive('0, ACTIVE_LOW));

  logic             slot_last;
  logic             nxt_blank;
  logic             nxt_last;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [NUM_DIGITS-1:0] on_sel;

  scan_prescaler #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_pre (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hold      (hold),
    .slot_last (slot_last),
    .nxt_blank (nxt_blank),
    .nxt_last  (nxt_last)
  );

  // Explicit wrap keeps non-power-of-2 counts in range
  always_comb begin
    idx_nxt = idx;
    if (!en)
      idx_nxt = '0;
    else if (!hold && slot_last)
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
  end

  assign on_sel =
    NUM_DIGITS'(drive(onehot(32'(idx_nxt)), ACTIVE_LOW));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      digit_sel  <= OFF;
      digit_idx  <= '0;
      tick       <= 1'b0;
      frame_done <= 1'b0;
    end else if (!en) begin
      idx        <= '0;
      digit_sel  <= OFF;
      digit_idx  <= '0;
      tick       <= 1'b0;
      frame_done <= 1'b0;
    end else if (hold) begin
      tick       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      idx        <= idx_nxt;
      digit_idx  <= idx_nxt;
      digit_sel  <= (!nxt_blank && digit_en[idx_nxt]) ? on_sel : OFF;
      tick       <= nxt_last;
      frame_done <= nxt_last && (idx_nxt == IDX_LAST);
    end
  end

endmodule
